micro_core_mc: RTL

Parametrised multi-cycle successor of the single-cycle 8-bit microprocessor core. It executes the same four-opcode ISA (ADD, LOAD, STORE, BRANCH) over configurable data width, register-file size, data-memory depth and PC width. It uses a FETCH/DECODE/EXEC/MEM/WB state machine with a wait-state instruction-fetch handshake, a hard-wired zero register, a halt input and a write-back display port. The core is clocked directly; any clock divider and the 7-segment drivers sit outside it.

---
 rtl/micro_core_mc.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/micro_core_mc.sv
// micro_core_mc: multi-cycle ADD/LOAD/STORE/BRANCH core with fetch handshake.
// Define MICRO_CORE_COND_BRANCH_EN to take BRANCH only when r[A] == 0.
module micro_core_mc #(
    parameter int DATA_W    = 8,
    parameter int REG_AW    = 2,
    parameter int MEM_DEPTH = 32,
    parameter int PC_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt,
    output logic                  instr_req,
    output logic [PC_W-1:0]       instruction_address,
    input  logic [2+3*REG_AW-1:0] instruction,
    input  logic                  instr_valid,
    output logic [1:0]            op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [REG_AW-1:0]     wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  instr_done
);
    localparam int INSTR_W = 2 + 3 * REG_AW;
    localparam int MEM_AW  = $clog2(MEM_DEPTH);
    localparam int NREG    = 1 << REG_AW;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   regs [NREG];
    logic [DATA_W-1:0]   mem  [MEM_DEPTH];
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [MEM_AW-1:0]   addr;

    logic [REG_AW-1:0]   fa;
    logic [REG_AW-1:0]   fb;
    logic [REG_AW-1:0]   fc;
    logic [DATA_W-1:0]   c_ext;
    logic [PC_W-1:0]     br_off;
    logic [PC_W-1:0]     pc_inc;
    logic                taken;

    assign op     = ir[INSTR_W-1 -: 2];
    assign fa     = ir[3*REG_AW-1 -: REG_AW];
    assign fb     = ir[2*REG_AW-1 -: REG_AW];
    assign fc     = ir[REG_AW-1:0];
    assign c_ext  = {{(DATA_W-REG_AW){fc[REG_AW-1]}}, fc};
    assign br_off = {{(PC_W-2*REG_AW){ir[2*REG_AW-1]}}, ir[2*REG_AW-1:0]};
    assign pc_inc = pc + PC_W'(1);

    assign instruction_address = pc;
    // Reset gating keeps the request quiet while the core is held in reset.
    assign instr_req = (state == FETCH) && !halt && !reset;

`ifdef MICRO_CORE_COND_BRANCH_EN
    assign taken = (opa == '0);
`else
    assign taken = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            addr       <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            instr_done <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            // Lower half counts up, upper half counts down from zero.
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= (i < MEM_DEPTH / 2) ? DATA_W'(i)
                                              : DATA_W'(MEM_DEPTH / 2 - i);
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            instr_done <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_req && instr_valid) begin
                        ir    <= instruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    opa        <= regs[fa];
                    opb        <= regs[fb];
                    instr_done <= (op == OP_BRANCH);
                    state      <= EXEC;
                end
                EXEC: begin
                    case (op)
                        OP_ADD: begin
                            if (fc != '0) begin
                                regs[fc]  <= opa + opb;
                                wb_reg    <= fc;
                                wb_data   <= opa + opb;
                                reg_write <= 1'b1;
                            end
                            instr_done <= 1'b1;
                            state      <= WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            addr       <= MEM_AW'(opa + c_ext);
                            mem_read   <= (op == OP_LOAD);
                            mem_write  <= (op == OP_STORE);
                            instr_done <= (op == OP_STORE);
                            state      <= MEM;
                        end
                        OP_BRANCH: begin
                            pc    <= taken ? pc_inc + br_off : pc_inc;
                            state <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (op == OP_LOAD) begin
                        if (fb != '0) begin
                            regs[fb]  <= mem[addr];
                            wb_reg    <= fb;
                            wb_data   <= mem[addr];
                            reg_write <= 1'b1;
                        end
                        instr_done <= 1'b1;
                        state      <= WB;
                    end else begin
                        mem[addr] <= opb;
                        pc        <= pc_inc;
                        state     <= FETCH;
                    end
                end
                WB: begin
                    pc    <= pc_inc;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
